i2c_target_rx: RTL

I2C_TARGET_RX -- requirements
Module: i2c_target_rx

---
 rtl/i2c_pkg.sv | 34 +++
 rtl/i2c_sync_edge.sv | 87 ++++++++
 rtl/i2c_target_rx.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C target receiver:
//   - BIT_CNT_W / CNT_* : width and key values of the per-byte bit counter
//   - i2c_state_e       : protocol state of the target FSM
//   - addr_match()      : compares the 7-bit address field of a received byte
// -----------------------------------------------------------------------------
package i2c_pkg;

  localparam int unsigned BIT_CNT_W = 4;

  localparam logic [BIT_CNT_W-1:0] CNT_ZERO = 4'd0;
  localparam logic [BIT_CNT_W-1:0] CNT_ONE  = 4'd1;
  localparam logic [BIT_CNT_W-1:0] CNT_LAST = 4'd7;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RX_ADDR   = 4'd1,
    ST_ACK_ADDR  = 4'd2,
    ST_RX_PTR    = 4'd3,
    ST_ACK_PTR   = 4'd4,
    ST_RX_DATA   = 4'd5,
    ST_ACK_DATA  = 4'd6,
    ST_TX_DATA   = 4'd7,
    ST_RX_MACK   = 4'd8,
    ST_WAIT_STOP = 4'd9
  } i2c_state_e;

  // Upper seven bits of an address byte carry the target address, bit 0 is R/W.
  function automatic logic addr_match(input logic [7:0] byte_in, input logic [6:0] dev);
    return (byte_in[7:1] == dev);
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// -----------------------------------------------------------------------------
// i2c_sync_edge
// Synchronises the SCL/SDA pads into clk, keeps one delayed copy of each and
// produces registered single-cycle bus events.
//   clk, rst   : system clock, synchronous active-high reset
//   scl_i      : SCL pad (asynchronous)
//   sda_i      : SDA pad (asynchronous)
//   scl_rise   : synchronised SCL rising edge
//   scl_fall   : synchronised SCL falling edge
//   start_det  : SDA fell while SCL high
//   stop_det   : SDA rose while SCL high
//   sda_bit    : synchronised SDA value in the same cycle as the events
// -----------------------------------------------------------------------------
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_bit
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic scl_dly_q, scl_dly_d;
  logic sda_dly_q, sda_dly_d;
  logic scl_rise_q, scl_rise_d;
  logic scl_fall_q, scl_fall_d;
  logic start_q, start_d;
  logic stop_q, stop_d;
  logic sda_bit_q, sda_bit_d;
  logic scl_s, sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Next-state of the synchroniser chains, delay flops and event detectors.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_dly_d  = scl_s;
    sda_dly_d  = sda_s;
    scl_rise_d = scl_s & ~scl_dly_q;
    scl_fall_d = ~scl_s & scl_dly_q;
    // SCL must be high in both samples so an SCL edge is never taken for START/STOP.
    start_d    = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
    stop_d     = scl_s & scl_dly_q & ~sda_dly_q & sda_s;
    sda_bit_d  = sda_s;
  end

  // Registers; reset loads an idle (high) bus so no spurious edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_bit_q  <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_dly_q  <= scl_dly_d;
      sda_dly_q  <= sda_dly_d;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      sda_bit_q  <= sda_bit_d;
    end
  end

  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign sda_bit   = sda_bit_q;

endmodule

// File: rtl/i2c_target_rx.sv
// -----------------------------------------------------------------------------
// i2c_target_rx
// I2C target with an 8-bit register pointer: writes are streamed to a register
// file through wr_en, reads are fetched through rd_req/rd_data.
//   clk, rst : system clock, synchronous active-high reset
//   scl_i    : SCL pad (asynchronous)
//   sda_i    : SDA pad (asynchronous)
//   sda_oe   : 1 pulls SDA low (open drain)
//   reg_addr : register pointer, auto-increments after each byte
//   wr_data  : received data byte, valid with wr_en
//   wr_en    : one-cycle write strobe
//   rd_req   : one-cycle read request for the byte at reg_addr
//   rd_data  : register byte, sampled one cycle after rd_req
//   busy     : bus transaction in progress (START to STOP)
// -----------------------------------------------------------------------------
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_bit;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_bit   (sda_bit)
  );

  i2c_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]           shift_q, shift_d;
  logic [7:0]           tx_q, tx_d;
  logic                 rw_q, rw_d;
  logic                 sda_oe_q, sda_oe_d;
  logic [7:0]           reg_addr_q, reg_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rd_req_q, rd_req_d;
  logic                 busy_q, busy_d;
  logic [7:0]           rx_byte_s;
  logic                 bit_last_s;

  assign rx_byte_s  = {shift_q, sda_bit};
  assign bit_last_s = (cnt_q == CNT_LAST);

  // Protocol FSM: next state, shifters, pointer and output strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    wr_en_d    = 1'b0;
    rd_req_d   = 1'b0;
    // Read byte arrives the cycle after the request.
    tx_d       = rd_req_q ? rd_data : tx_q;
    // Pointer advances the cycle after a committed write (wraps naturally).
    reg_addr_d = wr_en_q ? (reg_addr_q + 8'd1) : reg_addr_q;

    if (stop_det) begin
      state_d  = ST_IDLE;
      cnt_d    = CNT_ZERO;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      // Any partially shifted byte is dropped here.
      state_d  = ST_RX_ADDR;
      cnt_d    = CNT_ZERO;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        ST_RX_ADDR, ST_RX_PTR, ST_RX_DATA: begin
          if (scl_rise) begin
            shift_d = rx_byte_s[6:0];
            if (bit_last_s) begin
              cnt_d = CNT_ZERO;
              case (state_q)
                ST_RX_ADDR: begin
                  rw_d    = sda_bit;
                  state_d = addr_match(rx_byte_s, DEV_ADDR) ? ST_ACK_ADDR : ST_WAIT_STOP;
                end
                ST_RX_PTR: begin
                  reg_addr_d = rx_byte_s;
                  state_d    = ST_ACK_PTR;
                end
                default: begin
                  wr_data_d = rx_byte_s;
                  wr_en_d   = 1'b1;
                  state_d   = ST_ACK_DATA;
                end
              endcase
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (scl_fall) begin
            // Releases the preceding ACK on the falling edge after bit 9.
            sda_oe_d = 1'b0;
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        ST_ACK_ADDR, ST_ACK_PTR, ST_ACK_DATA: begin
          if (scl_fall) begin
            sda_oe_d = 1'b1;
          end else if (scl_rise) begin
            // 9th rising edge: ACK stays driven until the next falling edge.
            cnt_d = CNT_ZERO;
            case (state_q)
              ST_ACK_ADDR: begin
                rd_req_d = rw_q;
                state_d  = rw_q ? ST_TX_DATA : ST_RX_PTR;
              end
              default: state_d = ST_RX_DATA;
            endcase
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        ST_TX_DATA: begin
          if (scl_fall) begin
            sda_oe_d = ~tx_q[3'd7 - cnt_q[2:0]];
          end else if (scl_rise) begin
            cnt_d   = bit_last_s ? CNT_ZERO : (cnt_q + CNT_ONE);
            state_d = bit_last_s ? ST_RX_MACK : ST_TX_DATA;
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        ST_RX_MACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (!sda_bit) begin
              rd_req_d   = 1'b1;
              reg_addr_d = reg_addr_q + 8'd1;
              state_d    = ST_TX_DATA;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        ST_IDLE, ST_WAIT_STOP: begin
          sda_oe_d = scl_fall ? 1'b0 : sda_oe_q;
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      shift_q    <= 7'h00;
      tx_q       <= 8'h00;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      reg_addr_q <= 8'h00;
      wr_data_q  <= 8'h00;
      wr_en_q    <= 1'b0;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      reg_addr_q <= reg_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_req_q   <= rd_req_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign reg_addr = reg_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_en    = wr_en_q;
  assign rd_req   = rd_req_q;
  assign busy     = busy_q;

endmodule
